ps2_key_decoder: RTL
====================

// Module: ps2_key_decoder
// PURPOSE
//  Receives raw PS/2 keyboard clock/data and decodes scan-code set 2 into key events.
//  Output is one-cycle key_strobe with key_pressed/key_code/key_extended.
//  It is the producer side of the key-event interface consumed by the arcade input mapper.
//  It sits between the board PS/2 pins (or the userio PS/2 tunnel) and all keyboard-driven control logic.
// PARAMETERS
//  FILTER_LEN  8      consecutive identical samples needed before the filtered ps2_clk changes (1..255)
//  TIMEOUT     8000   clk cycles with no filtered falling edge, while mid-frame, before the frame is aborted (1..65535)
// PORTS
//  clk           in   1  system clock
//  reset         in   1  reset, synchronous, active-high
//  ps2_clk       in   1  raw PS/2 clock, asynchronous; idles high
//  ps2_data      in   1  raw PS/2 data, asynchronous; idles high
//  key_strobe    out  1  one-cycle pulse: new key event valid
//  key_pressed   out  1  1 = make, 0 = break; held until next strobe
//  key_extended  out  1  event was E0-prefixed; held until next strobe
//  key_code      out  8  scan code (prefixes removed); held until next strobe
//  frame_err     out  1  one-cycle pulse: parity error, stop-bit error or timeout
// BEHAVIOUR
//  - Reset: all outputs 0; FSM to IDLE; prefix flags cleared; filtered clock = 1; synchronisers = 1. Reset wins over any simultaneous event.
//  - Input conditioning:
//    - ps2_clk and ps2_data each pass through a 2-FF synchroniser.
//    - The filter counts consecutive synchronised ps2_clk samples that differ from the filtered value, and resets the count on a match.
//    - At FILTER_LEN the filtered value flips. A flip 1->0 is a falling edge (fe), valid for 1 cycle; data is sampled in that cycle.
//  - FSM (transitions only on fe, except timeout):
//    - IDLE: data=0 -> DATA with bit count 0; data=1 -> stay IDLE (spurious edge, no error).
//    - DATA: shift data in LSB first; after the 8th bit -> PARITY.
//    - PARITY: store bit -> STOP.
//    - STOP: if (odd parity over 8 data bits + parity bit OK) and data=1 -> byte complete. Otherwise pulse frame_err and clear the prefix flags. Go to IDLE in both cases.
//  - Timeout: a 16-bit counter clears on every fe and in IDLE, and increments otherwise. When it reaches TIMEOUT in a non-IDLE state: go to IDLE, discard partial byte, pulse frame_err, clear prefix flags.
//  - Byte handling (in the cycle after byte complete):
//    - 0xE0: set ext flag, no strobe.
//    - 0xF0: set brk flag, no strobe.
//    - 0xAA, 0xFA, 0xFE, 0xEE, 0x00, 0xFF: device responses; swallowed, both flags cleared, no strobe.
//    - Any other byte: key_strobe=1, key_code=byte, key_pressed=~brk, key_extended=ext; both flags cleared.
//  - Latency: key_strobe asserts exactly 2 cycles after the cycle of the stop-bit fe. frame_err asserts 1 cycle after the detecting cycle.
//  - Strobes are never back-to-back; a PS/2 frame is far longer than 2 cycles.
//  - Prefix flags persist across frames until consumed or cleared; E0 F0 and F0 E0 orders are both accepted.
//  - Host-to-device transmission is not supported: the block never drives ps2_clk/ps2_data.
// CONFIGURATION
//  PS2_PAUSE_DECODE_EN defined:
//    - 0xE1 (with no flag pending) starts a swallow counter; the next 7 bytes are consumed silently (14 77 E1 F0 14 F0 77).
//    - Then one strobe is emitted: key_code=0x77, key_pressed=1, key_extended=1. No break event is emitted.
//    - A frame_err or timeout during the sequence cancels it.
//  PS2_PAUSE_DECODE_EN undefined:
//    - 0xE1 is an ordinary byte.
//    - The Pause sequence yields strobes E1(make), 14(make), 77(make), E1(make), 14(break), 77(break).
// TESTING
//  1. Frame 0x1C, correct parity, 12.5 kHz bit clock -> one strobe, code=1C, pressed=1, ext=0, frame_err=0.
//  2. Frames F0,1C -> no strobe after F0; strobe after 1C with code=1C, pressed=0, ext=0.
//  3. Frames E0,F0,75 -> single strobe code=75, pressed=0, ext=1; a following 75 -> pressed=1, ext=0.
//  4. Frame 0x29 with parity bit inverted -> frame_err pulse, no strobe; next good 0x29 -> strobe code=29, pressed=1.
//  5. 5 data bits then ps2_clk held high for TIMEOUT cycles -> frame_err pulse, FSM IDLE; next good 0x16 -> strobe code=16. A 3-cycle ps2_clk glitch (FILTER_LEN=8) produces no bit.
//  6. Pause sequence E1 14 77 E1 F0 14 F0 77 -> with PS2_PAUSE_DECODE_EN: single strobe code=77, pressed=1, ext=1; without: 6 strobes as listed. Reset asserted mid-frame -> next frame decodes cleanly; 0xAA -> no strobe.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 keyboard receiver decoding scan-code set 2 into key events.
// Synchronises and glitch-filters the raw PS/2 lines, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop) and folds E0/F0 prefixes into
// one-cycle key_strobe events. Define PS2_PAUSE_DECODE_EN to collapse the
// 8-byte Pause sequence into a single extended make of code 0x77.
module ps2_key_decoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 8000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_strobe,
    output logic       key_pressed,
    output logic       key_extended,
    output logic [7:0] key_code,
    output logic       frame_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam logic [7:0]  FILT_LAST = 8'(FILTER_LEN - 1);
    localparam logic [15:0] TMO_LIM   = 16'(TIMEOUT);

    logic        clk_s1, clk_s2, dat_s1, dat_s2;
    logic        filt_clk;
    logic [7:0]  filt_cnt;
    logic        fe;

    state_t      state, state_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        par_bit, par_nxt;
    logic        byte_done, byte_done_nxt;
    logic        err_nxt;
    logic [15:0] tmo_cnt;
    logic        ext_flag, brk_flag;
`ifdef PS2_PAUSE_DECODE_EN
    logic [2:0]  pause_cnt;
`endif

    // Two-flop synchronisers for both raw PS/2 lines (idle high)
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Clock glitch filter: flip after FILTER_LEN consecutive differing samples; flag 1->0 flips
    always_ff @(posedge clk) begin
        if (reset) begin
            filt_clk <= 1'b1;
            filt_cnt <= '0;
            fe       <= 1'b0;
        end else begin
            fe <= 1'b0;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_LAST) begin
                filt_cnt <= '0;
                filt_clk <= clk_s2;
                fe       <= filt_clk;
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end
    end

    // Frame FSM next-state: advances on filtered falling edges, aborts on timeout
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        par_nxt       = par_bit;
        byte_done_nxt = 1'b0;
        err_nxt       = 1'b0;
        if (fe) begin
            case (state)
                S_IDLE: begin
                    if (!dat_s2) begin
                        state_nxt   = S_DATA;
                        bit_cnt_nxt = '0;
                    end
                end
                S_DATA: begin
                    shift_nxt   = {dat_s2, shift[7:1]};
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                end
                S_PARITY: begin
                    par_nxt   = dat_s2;
                    state_nxt = S_STOP;
                end
                S_STOP: begin
                    if ((^{shift, par_bit}) && dat_s2) byte_done_nxt = 1'b1;
                    else                               err_nxt       = 1'b1;
                    state_nxt = S_IDLE;
                end
                default: state_nxt = S_IDLE;
            endcase
        end else if (state != S_IDLE && tmo_cnt >= TMO_LIM) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
        end
    end

    // Frame FSM registers and error pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_bit   <= 1'b0;
            byte_done <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift     <= shift_nxt;
            par_bit   <= par_nxt;
            byte_done <= byte_done_nxt;
            frame_err <= err_nxt;
        end
    end

    // Inactivity counter: cleared on every falling edge and while idle
    always_ff @(posedge clk) begin
        if (reset || fe || state == S_IDLE) tmo_cnt <= '0;
        else if (tmo_cnt != '1)             tmo_cnt <= tmo_cnt + 16'd1;
    end

    // Byte interpretation: prefixes, device responses, key events; errors clear pending prefixes
    always_ff @(posedge clk) begin
        if (reset) begin
            key_strobe   <= 1'b0;
            key_pressed  <= 1'b0;
            key_extended <= 1'b0;
            key_code     <= '0;
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
`ifdef PS2_PAUSE_DECODE_EN
            pause_cnt    <= '0;
`endif
        end else begin
            key_strobe <= 1'b0;
            if (byte_done) begin
`ifdef PS2_PAUSE_DECODE_EN
                // Pause swallow takes precedence over normal decoding of its tail bytes
                if (pause_cnt != 3'd0) begin
                    pause_cnt <= pause_cnt - 3'd1;
                    if (pause_cnt == 3'd1) begin
                        key_strobe   <= 1'b1;
                        key_code     <= 8'h77;
                        key_pressed  <= 1'b1;
                        key_extended <= 1'b1;
                        ext_flag     <= 1'b0;
                        brk_flag     <= 1'b0;
                    end
                end else if (shift == 8'hE1 && !ext_flag && !brk_flag) begin
                    pause_cnt <= 3'd7;
                end else
`endif
                begin
                    case (shift)
                        8'hE0: ext_flag <= 1'b1;
                        8'hF0: brk_flag <= 1'b1;
                        8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                            ext_flag <= 1'b0;
                            brk_flag <= 1'b0;
                        end
                        default: begin
                            key_strobe   <= 1'b1;
                            key_code     <= shift;
                            key_pressed  <= ~brk_flag;
                            key_extended <= ext_flag;
                            ext_flag     <= 1'b0;
                            brk_flag     <= 1'b0;
                        end
                    endcase
                end
            end
            if (err_nxt) begin
                ext_flag  <= 1'b0;
                brk_flag  <= 1'b0;
`ifdef PS2_PAUSE_DECODE_EN
                pause_cnt <= '0;
`endif
            end
        end
    end

endmodule
